mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter in front of a fixed-latency memory.
// Define ARB_FAIRNESS_EN to stop data traffic from starving fetches.
module mem_arbiter #(
  parameter int unsigned LATENCY  = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [1:0]  dm_size,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic        dm_err,
  output logic [31:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        gnt_dm;
  logic        r_we;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_err;
  logic [31:0] if_q;
  logic [31:0] dm_q;

  logic pick_dm;
  logic misalign;

  always_comb begin
    misalign = 1'b0;
    unique case (1'b1)
      dm_size == 2'b01: misalign = dm_addr[0];
      dm_size[1]:       misalign = |dm_addr[1:0];
      default:          misalign = 1'b0;
    endcase
  end

`ifdef ARB_FAIRNESS_EN
  localparam logic [3:0] MW = 4'(MAX_WAIT);

  logic [3:0] starve;

  // Once the fetch side has lost MAX_WAIT times in a row it wins next.
  assign pick_dm = dm_req && !(if_req && starve == MW);

  always_ff @(posedge clock) begin
    if (reset) begin
      starve <= 4'd0;
    end else if (state == IDLE) begin
      if (pick_dm && if_req)
        starve <= starve + 4'd1;
      else if (!pick_dm && if_req)
        starve <= 4'd0;
    end
  end
`else
  assign pick_dm = dm_req;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      gnt_dm  <= 1'b0;
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_err   <= 1'b0;
      if_q    <= 32'd0;
      dm_q    <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= 4'd0;
          if (pick_dm) begin
            gnt_dm  <= 1'b1;
            r_we    <= dm_we;
            r_size  <= dm_size;
            r_addr  <= dm_addr;
            r_wdata <= dm_wdata;
            r_err   <= misalign;
            state   <= misalign ? DONE : ISSUE;
          end else if (if_req) begin
            gnt_dm  <= 1'b0;
            r_we    <= 1'b0;
            r_size  <= 2'b10;
            r_addr  <= if_addr;
            r_err   <= 1'b0;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= 4'd0;
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == LAT_M1) begin
            state <= DONE;
            if (gnt_dm)
              dm_q <= mem_rdata;
            else
              if_q <= mem_rdata;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_en    = state == ISSUE;
  assign mem_we    = mem_en && r_we;
  assign mem_size  = r_size;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  assign if_ack   = state == DONE && !gnt_dm;
  assign dm_ack   = state == DONE && gnt_dm;
  assign dm_err   = dm_ack && r_err;
  assign if_rdata = if_q;
  assign dm_rdata = dm_q;
  assign busy     = state != IDLE;

endmodule
